// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: stall/redirect control, ROM request/response and the decode-facing outputs.
// master = fetch unit, slave = surrounding pipeline / ROM / test environment.
interface inst_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_misalign;

  // Decode-facing contract: if_instr/if_pc are consumed only in cycles where if_valid=1;
  // stall=1 means decode did not take the word and the same word is presented again next cycle.
  modport master (
    input  stall, redirect_valid, redirect_target, rom_data,
    output rom_addr, if_valid, if_instr, if_pc, if_pc_plus4, if_misalign
  );

  modport slave (
    output stall, redirect_valid, redirect_target, rom_data,
    input  rom_addr, if_valid, if_instr, if_pc, if_pc_plus4, if_misalign
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// PC / fetch control in front of a synchronous ROM: replays on stall, squashes on redirect.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises a sticky if_misalign and halts fetch.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 8
) (
  input logic         clock,
  input logic         reset,
  inst_fetch_if.master bus
);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
    $error("inst_fetch_unit: ADDR_WIDTH must be in 1..30");
  end

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic        misalign_q;
  logic [31:0] target_al;
  logic        target_bad;

  assign target_al  = {bus.redirect_target[31:2], 2'b00};
  assign target_bad = |bus.redirect_target[1:0];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_d;
`else
  assign misalign_q = 1'b0;
`endif

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif
    if (bus.redirect_valid) begin
      resp_pc_d    = target_al;
      fetch_pc_d   = target_al + 32'd4;
      resp_valid_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d   = target_bad;
`endif
    end else if (!bus.stall && !misalign_q) begin
      resp_pc_d    = fetch_pc_q;
      fetch_pc_d   = fetch_pc_q + 32'd4;
      resp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`else
  logic unused_target_bad;
  assign unused_target_bad = target_bad;
`endif

  // Stall and trap both re-read the held word so rom_data stays aligned with resp_pc.
  always_comb begin
    if (reset)                     bus.rom_addr = RESET_PC;
    else if (bus.redirect_valid)   bus.rom_addr = target_al;
    else if (bus.stall || misalign_q) bus.rom_addr = resp_pc_q;
    else                           bus.rom_addr = fetch_pc_q;
  end

  assign bus.if_valid    = ~reset & resp_valid_q & ~bus.redirect_valid & ~misalign_q;
  assign bus.if_instr    = bus.rom_data;
  assign bus.if_pc       = reset ? RESET_PC : resp_pc_q;
  assign bus.if_pc_plus4 = bus.if_pc + 32'd4;
  assign bus.if_misalign = misalign_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit (default build): directed plan followed by random stall/redirect traffic.
module tb_inst_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int W = 97;  // {valid, pc, instr, rom_addr}

  logic clock;
  logic reset;
  inst_fetch_if bus ();

  inst_fetch_unit #(.RESET_PC(RESET_PC), .ADDR_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   rom_word = 32'h1111_1111;
      32'h4:   rom_word = 32'h2222_2222;
      32'h8:   rom_word = 32'h3333_3333;
      32'hC:   rom_word = 32'h4444_4444;
      default: rom_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  always @(posedge clock) bus.rom_data <= rom_word(bus.rom_addr);

  // Reference model: the word requested this cycle is the word shown next cycle;
  // something is shown once a non-stalled (or redirected) cycle has passed since reset.
  logic [31:0] m_pc;
  logic        m_have;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver
  task automatic drive(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
    logic        e_valid;
    logic [31:0] e_addr;
    @(posedge clock);
    #1;
    reset               = rst;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    if (rst) begin
      exp_q.push_back({1'b0, RESET_PC, 32'h0, RESET_PC});
      m_pc   = RESET_PC;
      m_have = 1'b0;
    end else begin
      e_valid = m_have & ~rv;
      if (rv)          e_addr = tgt & ~32'd3;
      else if (st)     e_addr = m_pc;
      else if (m_have) e_addr = m_pc + 32'd4;
      else             e_addr = m_pc;
      exp_q.push_back({e_valid, m_pc, rom_word(m_pc), e_addr});
      m_pc = e_addr;
      if (rv || !st) m_have = 1'b1;
    end
    mon_en = 1;
  endtask

  // Monitor: one expected entry per cycle
  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL queue_underflow at %0t", $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("if_valid",    {31'd0, bus.if_valid}, {31'd0, e[96]});
        check("if_pc",       bus.if_pc, e[95:64]);
        check("if_pc_plus4", bus.if_pc_plus4, e[95:64] + 32'd4);
        check("rom_addr",    bus.rom_addr, e[31:0]);
        check("if_misalign", {31'd0, bus.if_misalign}, 32'd0);
        if (e[96]) check("if_instr", bus.if_instr, e[63:32]);
      end
    end
  end

  initial begin
    logic        st, rv;
    logic [31:0] tgt;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    m_pc = RESET_PC;
    m_have = 1'b0;

    // Reset release and sequential fetch
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    // Stall held on the word at 4
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    // Redirect while showing 8
    drive(0, 0, 1, 32'h40);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    // Redirect and stall together
    drive(0, 1, 1, 32'h20);
    drive(0, 0, 0, 0);
    // Wrap-around
    drive(0, 0, 1, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    // Misaligned redirect (low bits masked)
    drive(0, 0, 1, 32'h42);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    // Reset dominating a redirect, then stall in the first cycle after reset
    drive(1, 1, 1, 32'h100);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
        1:       tgt = $urandom;
        default: tgt = $urandom & 32'h0000_0FFC;
      endcase
      drive(($urandom_range(0, 99) == 0), st, rv, tgt);
    end
    drive(0, 0, 0, 0);

    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
